// File: rtl/rvfi_retire_comparator.sv
// Pairs reference-model and DUT RVFI retirements in order, compares them
// field by field and reports per-pair results, counters and sticky flags.
//
// state  | meaning
// ACTIVE | popping and comparing one pair per cycle while both sides hold data
// HALTED | comparison stopped (mismatch or timeout); only reset leaves it
module rvfi_retire_comparator #(
    parameter int DEPTH            = 8,
    parameter int TIMEOUT          = 1000,
    parameter int STOP_ON_MISMATCH = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ref_valid_i,
    input  logic [63:0] ref_order_i,
    input  logic [31:0] ref_pc_i,
    input  logic [31:0] ref_insn_i,
    input  logic        ref_trap_i,
    input  logic [4:0]  ref_rd_addr_i,
    input  logic [31:0] ref_rd_wdata_i,
    input  logic        dut_valid_i,
    input  logic [63:0] dut_order_i,
    input  logic [31:0] dut_pc_i,
    input  logic [31:0] dut_insn_i,
    input  logic        dut_trap_i,
    input  logic [4:0]  dut_rd_addr_i,
    input  logic [31:0] dut_rd_wdata_i,
    output logic        cmp_valid_o,
    output logic        cmp_mismatch_o,
    output logic [5:0]  cmp_field_o,
    output logic [63:0] cmp_order_o,
    output logic [31:0] match_cnt_o,
    output logic [31:0] mismatch_cnt_o,
    output logic        overflow_o,
    output logic        timeout_o,
    output logic        halted_o
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        trap;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
    } entry_t;

    typedef enum logic {
        ACTIVE,
        HALTED
    } state_t;

    // Index 0 is the reference side, index 1 the DUT side.
    state_t      state;
    state_t      state_next;
    entry_t      in_entry [2];
    entry_t      head     [2];
    entry_t      mem      [2][DEPTH];
    logic [AW:0] wr_ptr   [2];
    logic [AW:0] rd_ptr   [2];
    logic [1:0]  valid;
    logic [1:0]  empty;
    logic [1:0]  full;
    logic [1:0]  push;
    logic [1:0]  drop;
    logic        pop;
    logic        one_side;
    logic        both_trap;
    logic        tmo_hit;
    logic [5:0]  field;
    logic [31:0] tmo_cnt;

    assign in_entry[0] = {ref_order_i, ref_pc_i, ref_insn_i, ref_trap_i,
                          ref_rd_addr_i, ref_rd_wdata_i};
    assign in_entry[1] = {dut_order_i, dut_pc_i, dut_insn_i, dut_trap_i,
                          dut_rd_addr_i, dut_rd_wdata_i};
    assign valid       = {dut_valid_i, ref_valid_i};

    // FIFO status and head-of-queue read for both sides.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                       (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
            head[i]  = mem[i][rd_ptr[i][AW-1:0]];
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    always_comb begin
        pop      = (state == ACTIVE) && !empty[0] && !empty[1];
        one_side = (empty[0] != empty[1]);
        for (int i = 0; i < 2; i++) begin
            push[i] = valid[i] && (!full[i] || pop);
            drop[i] = valid[i] && full[i] && !pop;
        end
    end

    // Field comparison; rd fields are ignored when both sides trapped,
    // and rd_wdata only matters when the reference wrote a real register.
    always_comb begin
        field     = '0;
        both_trap = head[0].trap && head[1].trap;
        field[0]  = (head[0].order != head[1].order);
        field[1]  = (head[0].pc    != head[1].pc);
        field[2]  = (head[0].insn  != head[1].insn);
        field[3]  = (head[0].trap  != head[1].trap);
        if (!both_trap) begin
            field[4] = (head[0].rd_addr != head[1].rd_addr);
            if (head[0].rd_addr != 5'd0) begin
                field[5] = (head[0].rd_wdata != head[1].rd_wdata);
            end
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop)     rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= in_entry[i];
        end
    end

    // Registered compare results, saturating counters and the overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmp_valid_o    <= 1'b0;
            cmp_mismatch_o <= 1'b0;
            cmp_field_o    <= '0;
            cmp_order_o    <= '0;
            match_cnt_o    <= '0;
            mismatch_cnt_o <= '0;
            overflow_o     <= 1'b0;
        end else begin
            cmp_valid_o <= pop;
            if (pop) begin
                cmp_mismatch_o <= |field;
                cmp_field_o    <= field;
                cmp_order_o    <= head[1].order;
                if (|field) begin
                    if (mismatch_cnt_o != '1) mismatch_cnt_o <= mismatch_cnt_o + 32'd1;
                end else begin
                    if (match_cnt_o != '1) match_cnt_o <= match_cnt_o + 32'd1;
                end
            end
            if (|drop) overflow_o <= 1'b1;
        end
    end

    // Starvation timer: runs while only one side holds entries.
    assign tmo_hit = one_side && (tmo_cnt >= TIMEOUT_M1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt   <= '0;
            timeout_o <= 1'b0;
        end else if (pop || (empty[0] && empty[1])) begin
            tmo_cnt <= '0;
        end else if (one_side) begin
            if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 32'd1;
            if (tmo_hit) timeout_o <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ACTIVE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ACTIVE: begin
                if (((STOP_ON_MISMATCH != 0) && pop && (|field)) || tmo_hit || timeout_o) begin
                    state_next = HALTED;
                end
            end
            HALTED:  state_next = HALTED;
            default: state_next = ACTIVE;
        endcase
    end

    assign halted_o = (state == HALTED);

endmodule

// File: tb/tb_rvfi_retire_comparator.sv
// Directed bench for rvfi_retire_comparator with a queue-based reference model
// that is stepped once per clock and checked against every DUT output.
module tb_rvfi_retire_comparator;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 10;
    localparam int STOP    = 1;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        trap;
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ref_valid = 1'b0;
    logic        dut_valid = 1'b0;
    ent_t        ref_e = '0;
    ent_t        dut_e = '0;

    logic        cmp_valid;
    logic        cmp_mismatch;
    logic [5:0]  cmp_field;
    logic [63:0] cmp_order;
    logic [31:0] match_cnt;
    logic [31:0] mismatch_cnt;
    logic        overflow;
    logic        timeout;
    logic        halted;

    always #5 clk = ~clk;

    rvfi_retire_comparator #(
        .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STOP_ON_MISMATCH(STOP)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .ref_valid_i(ref_valid), .ref_order_i(ref_e.order), .ref_pc_i(ref_e.pc),
        .ref_insn_i(ref_e.insn), .ref_trap_i(ref_e.trap), .ref_rd_addr_i(ref_e.rd),
        .ref_rd_wdata_i(ref_e.wd),
        .dut_valid_i(dut_valid), .dut_order_i(dut_e.order), .dut_pc_i(dut_e.pc),
        .dut_insn_i(dut_e.insn), .dut_trap_i(dut_e.trap), .dut_rd_addr_i(dut_e.rd),
        .dut_rd_wdata_i(dut_e.wd),
        .cmp_valid_o(cmp_valid), .cmp_mismatch_o(cmp_mismatch), .cmp_field_o(cmp_field),
        .cmp_order_o(cmp_order), .match_cnt_o(match_cnt), .mismatch_cnt_o(mismatch_cnt),
        .overflow_o(overflow), .timeout_o(timeout), .halted_o(halted)
    );

    // Reference model state.
    ent_t        mref[$];
    ent_t        mdut[$];
    logic        e_valid = 1'b0;
    logic        e_mis   = 1'b0;
    logic [5:0]  e_field = '0;
    logic [63:0] e_order = '0;
    logic [31:0] e_match = '0;
    logic [31:0] e_mism  = '0;
    logic        e_ovf   = 1'b0;
    logic        e_tmo   = 1'b0;
    logic        e_halt  = 1'b0;
    int          tcnt    = 0;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [5:0] fields(ent_t r, ent_t d);
        logic [5:0] f;
        f    = '0;
        f[0] = (r.order != d.order);
        f[1] = (r.pc != d.pc);
        f[2] = (r.insn != d.insn);
        f[3] = (r.trap != d.trap);
        if (!(r.trap && d.trap)) begin
            f[4] = (r.rd != d.rd);
            if (r.rd != 5'd0) f[5] = (r.wd != d.wd);
        end
        return f;
    endfunction

    function automatic ent_t mk(int n);
        ent_t e;
        e.order = 64'(n);
        e.pc    = 32'h80 + 32'(4 * n);
        e.insn  = 32'h0000_0013 | (32'(n) << 20);
        e.trap  = 1'b0;
        e.rd    = 5'(n);
        e.wd    = 32'(n * 3 + 1);
        return e;
    endfunction

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        ent_t       r;
        ent_t       d;
        logic       pop;
        logic [5:0] f;
        int         rs;
        int         ds;
        if (rst) begin
            mref.delete();
            mdut.delete();
            e_valid = 0; e_mis = 0; e_field = '0; e_order = '0;
            e_match = '0; e_mism = '0; e_ovf = 0; e_tmo = 0; e_halt = 0; tcnt = 0;
        end else begin
            rs  = mref.size();
            ds  = mdut.size();
            pop = !e_halt && (rs > 0) && (ds > 0);
            if (pop || (rs == 0 && ds == 0)) begin
                tcnt = 0;
            end else if ((rs > 0) != (ds > 0)) begin
                tcnt++;
                if (tcnt >= TIMEOUT) e_tmo = 1'b1;
            end
            e_valid = pop;
            if (pop) begin
                r       = mref.pop_front();
                d       = mdut.pop_front();
                f       = fields(r, d);
                e_field = f;
                e_mis   = (f != 6'd0);
                e_order = d.order;
                if (f != 6'd0) begin
                    if (e_mism != 32'hFFFF_FFFF) e_mism++;
                    if (STOP != 0) e_halt = 1'b1;
                end else begin
                    if (e_match != 32'hFFFF_FFFF) e_match++;
                end
            end
            if (ref_valid) begin
                if (rs < DEPTH || pop) mref.push_back(ref_e);
                else e_ovf = 1'b1;
            end
            if (dut_valid) begin
                if (ds < DEPTH || pop) mdut.push_back(dut_e);
                else e_ovf = 1'b1;
            end
            if (e_tmo) e_halt = 1'b1;
        end
    endtask

    task automatic cmp1(string name, logic [63:0] act, logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic check();
        n_vec++;
        cmp1("cmp_valid",    64'(cmp_valid),    64'(e_valid));
        cmp1("cmp_mismatch", 64'(cmp_mismatch), 64'(e_mis));
        cmp1("cmp_field",    64'(cmp_field),    64'(e_field));
        cmp1("cmp_order",    cmp_order,         e_order);
        cmp1("match_cnt",    64'(match_cnt),    64'(e_match));
        cmp1("mismatch_cnt", 64'(mismatch_cnt), 64'(e_mism));
        cmp1("overflow",     64'(overflow),     64'(e_ovf));
        cmp1("timeout",      64'(timeout),      64'(e_tmo));
        cmp1("halted",       64'(halted),       64'(e_halt));
    endtask

    task automatic lit(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        cmp1(name, act, exp);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check();
        ref_valid = 1'b0;
        dut_valid = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
    endtask

    int         pulses;
    logic [5:0] seen_field;

    initial begin
        // Reset state
        do_reset();
        lit("reset_match_cnt", 64'(match_cnt), 64'd0);
        lit("reset_halted", 64'(halted), 64'd0);

        // Identical streams, both sides in the same cycle
        for (int n = 1; n <= 20; n++) begin
            ref_e = mk(n); dut_e = mk(n); ref_valid = 1'b1; dut_valid = 1'b1;
            step();
            if (n == 1) lit("latency_first_edge", 64'(cmp_valid), 64'd0);
            if (n == 2) begin
                lit("latency_second_edge", 64'(cmp_valid), 64'd1);
                lit("first_order", cmp_order, 64'd1);
            end
        end
        step(); step();
        lit("ident_match_cnt", 64'(match_cnt), 64'd20);
        lit("ident_mismatch_cnt", 64'(mismatch_cnt), 64'd0);

        // DUT leads by five retirements
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            dut_e = mk(n); dut_valid = 1'b1; step();
        end
        for (int n = 1; n <= 5; n++) begin
            ref_e = mk(n); ref_valid = 1'b1; step();
        end
        step(); step();
        lit("skew_match_cnt", 64'(match_cnt), 64'd5);
        lit("skew_overflow", 64'(overflow), 64'd0);
        lit("skew_timeout", 64'(timeout), 64'd0);

        // rd_wdata mismatch on pair 3 halts the comparator
        do_reset();
        pulses = 0; seen_field = '0;
        for (int n = 1; n <= 9; n++) begin
            if (n <= 5) begin
                ref_e = mk(n); dut_e = mk(n);
                ref_e.rd = 5'd5; dut_e.rd = 5'd5;
                if (n == 3) begin ref_e.wd = 32'h1234; dut_e.wd = 32'h1235; end
                ref_valid = 1'b1; dut_valid = 1'b1;
            end
            step();
            if (cmp_valid) pulses++;
            if (cmp_valid && cmp_mismatch) seen_field = cmp_field;
        end
        lit("mis_field", 64'(seen_field), 64'b100000);
        lit("mis_mismatch_cnt", 64'(mismatch_cnt), 64'd1);
        lit("mis_match_cnt", 64'(match_cnt), 64'd2);
        lit("mis_halted", 64'(halted), 64'd1);
        lit("mis_pulses", 64'(pulses), 64'd3);

        // rd_addr 0 and double-trap masking, then a lone trap difference
        do_reset();
        seen_field = '0;
        for (int n = 1; n <= 5; n++) begin
            if (n == 1) begin
                ref_e = mk(1); dut_e = mk(1); ref_e.rd = 5'd0; dut_e.rd = 5'd0;
                ref_e.wd = 32'hDEAD; dut_e.wd = 32'hBEEF;
            end else if (n == 2) begin
                ref_e = mk(2); dut_e = mk(2); ref_e.trap = 1'b1; dut_e.trap = 1'b1;
                ref_e.rd = 5'd3; dut_e.rd = 5'd4; ref_e.wd = 32'd1; dut_e.wd = 32'd2;
            end else if (n == 3) begin
                ref_e = mk(3); dut_e = mk(3); ref_e.trap = 1'b1;
            end
            if (n <= 3) begin ref_valid = 1'b1; dut_valid = 1'b1; end
            step();
            if (cmp_valid && cmp_mismatch) seen_field = cmp_field;
        end
        lit("mask_match_cnt", 64'(match_cnt), 64'd2);
        lit("mask_mismatch_cnt", 64'(mismatch_cnt), 64'd1);
        lit("trap_field", 64'(seen_field), 64'b001000);

        // Overflow on the 9th DUT push, timeout ten cycles after the first
        do_reset();
        for (int n = 1; n <= 9; n++) begin
            dut_e = mk(n); dut_valid = 1'b1; step();
            if (n == 8) lit("ovf_before", 64'(overflow), 64'd0);
            if (n == 9) lit("ovf_after", 64'(overflow), 64'd1);
        end
        step();
        lit("tmo_before", 64'(timeout), 64'd0);
        step();
        lit("tmo_after", 64'(timeout), 64'd1);
        lit("tmo_halted", 64'(halted), 64'd1);
        step();

        // Reset in the middle of a stream discards buffered entries
        do_reset();
        ref_e = mk(1); dut_e = mk(1); ref_valid = 1'b1; dut_valid = 1'b1; step();
        step(); step();
        for (int n = 40; n < 43; n++) begin
            ref_e = mk(n); ref_valid = 1'b1; step();
        end
        do_reset();
        lit("midrst_match_cnt", 64'(match_cnt), 64'd0);
        lit("midrst_halted", 64'(halted), 64'd0);
        ref_e = mk(7); dut_e = mk(7); ref_valid = 1'b1; dut_valid = 1'b1; step();
        step(); step();
        lit("midrst_after_match", 64'(match_cnt), 64'd1);
        lit("midrst_after_mismatch", 64'(mismatch_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
